// File: rtl/usb_hub_port_ctrl.sv
// Downstream hub port controller: power, connect debounce, bus reset, enable/disable,
// suspend/resume sequencing, line-state speed latching and the port's SE0/K drivers.
module usb_hub_port_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 100,
   parameter int unsigned RESET_CYCLES    = 500,
   parameter int unsigned RESUME_CYCLES   = 200,
   parameter int unsigned DISC_CYCLES     = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] line_state_i,
   input  logic       port_power_i,
   input  logic       cmd_reset_i,
   input  logic       cmd_disable_i,
   input  logic       cmd_suspend_i,
   input  logic       cmd_resume_i,
   output logic       drive_en_o,
   output logic [1:0] drive_line_o,
   output logic [2:0] state_o,
   output logic       connected_o,
   output logic       port_enabled_o,
   output logic       port_suspended_o,
   output logic       low_speed_o,
   output logic [1:0] j_state_o,
   output logic [1:0] k_state_o,
   output logic [1:0] idle_state_o,
   output logic       conn_change_o,
   output logic       reset_done_o
);

   localparam logic [2:0] StOff        = 3'd0;
   localparam logic [2:0] StDisconn    = 3'd1;
   localparam logic [2:0] StDebounce   = 3'd2;
   localparam logic [2:0] StDisabled   = 3'd3;
   localparam logic [2:0] StResetting  = 3'd4;
   localparam logic [2:0] StEnabled    = 3'd5;
   localparam logic [2:0] StSuspended  = 3'd6;
   localparam logic [2:0] StResuming   = 3'd7;

   // Resume runs RESUME_CYCLES of K plus a 2-cycle EOP, so the counter must reach that too.
   localparam int unsigned MaxAB  = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : RESET_CYCLES;
   localparam int unsigned MaxCD  = ((RESUME_CYCLES + 1) > DISC_CYCLES) ? (RESUME_CYCLES + 1)
                                                                         : DISC_CYCLES;
   localparam int unsigned CntMax = (MaxAB > MaxCD) ? MaxAB : MaxCD;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   logic [1:0]      ls_meta_q, ls_s_q;
   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]      cap_q, cap_d;
   logic [1:0]      j_q, j_d;
   logic            low_q, low_d;
   logic            conn_change_q, conn_change_d;
   logic            reset_done_q, reset_done_d;
   logic            se0, monitor, disc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ls_meta_q     <= 2'b00;
         ls_s_q        <= 2'b00;
         state_q       <= StOff;
         cnt_q         <= '0;
         cap_q         <= 2'b00;
         j_q           <= 2'b10;
         low_q         <= 1'b0;
         conn_change_q <= 1'b0;
         reset_done_q  <= 1'b0;
      end else begin
         ls_meta_q     <= line_state_i;
         ls_s_q        <= ls_meta_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cap_q         <= cap_d;
         j_q           <= j_d;
         low_q         <= low_d;
         conn_change_q <= conn_change_d;
         reset_done_q  <= reset_done_d;
      end
   end

   assign cnt_inc = (cnt_q == CntW'(CntMax)) ? cnt_q : cnt_q + 1'b1;
   assign se0     = (ls_s_q == 2'b00);
   assign monitor = (state_q == StDisabled) || (state_q == StEnabled) ||
                    (state_q == StSuspended);
   assign disc    = monitor && se0 && (cnt_q == CntW'(DISC_CYCLES - 1));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_inc;
      cap_d         = cap_q;
      j_d           = j_q;
      low_d         = low_q;
      conn_change_d = 1'b0;
      reset_done_d  = 1'b0;
      if (!port_power_i) begin
         state_d       = StOff;
         cnt_d         = '0;
         conn_change_d = (state_q >= StDisabled);
      end else if (disc) begin
         state_d       = StDisconn;
         cnt_d         = '0;
         conn_change_d = 1'b1;
      end else begin
         // In the monitored states the counter tracks the current run of SE0 samples.
         if (monitor && !se0) begin
            cnt_d = '0;
         end
         case (state_q)
            StOff: begin
               state_d = StDisconn;
               cnt_d   = '0;
            end
            StDisconn: begin
               cnt_d = '0;
               if (ls_s_q == 2'b10 || ls_s_q == 2'b01) begin
                  state_d = StDebounce;
                  cap_d   = ls_s_q;
               end
            end
            StDebounce: begin
               if (ls_s_q != cap_q) begin
                  state_d = StDisconn;
                  cnt_d   = '0;
               end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                  state_d       = StDisabled;
                  cnt_d         = '0;
                  j_d           = cap_q;
                  low_d         = (cap_q == 2'b01);
                  conn_change_d = 1'b1;
               end
            end
            StDisabled: begin
               if (cmd_reset_i) begin
                  state_d = StResetting;
                  cnt_d   = '0;
               end
            end
            StResetting: begin
               if (cmd_reset_i) begin
                  cnt_d = '0;
               end else if (cmd_disable_i) begin
                  state_d = StDisabled;
                  cnt_d   = '0;
               end else if (cnt_q == CntW'(RESET_CYCLES - 1)) begin
                  state_d      = StEnabled;
                  cnt_d        = '0;
                  reset_done_d = 1'b1;
               end
            end
            StEnabled: begin
               if (cmd_reset_i) begin
                  state_d = StResetting;
                  cnt_d   = '0;
               end else if (cmd_disable_i) begin
                  state_d = StDisabled;
                  cnt_d   = '0;
               end else if (cmd_suspend_i) begin
                  state_d = StSuspended;
                  cnt_d   = '0;
               end
            end
            StSuspended: begin
               if (cmd_reset_i) begin
                  state_d = StResetting;
                  cnt_d   = '0;
               end else if (cmd_disable_i) begin
                  state_d = StDisabled;
                  cnt_d   = '0;
               end else if (cmd_resume_i || ls_s_q == ~j_q) begin
                  state_d = StResuming;
                  cnt_d   = '0;
               end
            end
            default: begin
               if (cmd_reset_i) begin
                  state_d = StResetting;
                  cnt_d   = '0;
               end else if (cnt_q == CntW'(RESUME_CYCLES + 1)) begin
                  state_d = StEnabled;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   assign drive_en_o       = (state_q == StResetting) || (state_q == StResuming);
   assign drive_line_o     = (state_q == StResuming && cnt_q < CntW'(RESUME_CYCLES)) ? ~j_q
                                                                                      : 2'b00;
   assign state_o          = state_q;
   assign connected_o      = (state_q >= StDisabled);
   assign port_enabled_o   = (state_q >= StEnabled);
   assign port_suspended_o = (state_q >= StSuspended);
   assign low_speed_o      = low_q;
   assign j_state_o        = j_q;
   assign k_state_o        = ~j_q;
   assign idle_state_o     = j_q;
   assign conn_change_o    = conn_change_q;
   assign reset_done_o     = reset_done_q;

endmodule

// File: tb/tb_usb_hub_port_ctrl.sv
// Bench for usb_hub_port_ctrl: directed scenarios plus random line/command traffic, all
// compared each cycle against a timestamp-based reference model.
module tb_usb_hub_port_ctrl;

   localparam int DebCyc = 100;
   localparam int RstCyc = 500;
   localparam int ResCyc = 200;
   localparam int DiscCyc = 3;

   localparam int SOff = 0, SDisconn = 1, SDebounce = 2, SDisabled = 3;
   localparam int SResetting = 4, SEnabled = 5, SSuspended = 6, SResuming = 7;

   logic       clock, reset;
   logic [1:0] line;
   logic       power, c_rst, c_dis, c_sus, c_res;
   logic       drive_en, connected, port_enabled, port_suspended, low_speed;
   logic       conn_change, reset_done;
   logic [1:0] drive_line, j_state, k_state, idle_state;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // reference model
   int         m_st, t_enter, se0_run;
   logic [1:0] m_cap, m_j, p_meta, p_s;
   logic       m_low, m_conn, m_rd;

   // observation helpers
   bit rd_seen, cc_seen;
   int k_cnt, eop_cnt;

   usb_hub_port_ctrl #(
      .DEBOUNCE_CYCLES(DebCyc),
      .RESET_CYCLES   (RstCyc),
      .RESUME_CYCLES  (ResCyc),
      .DISC_CYCLES    (DiscCyc)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .line_state_i    (line),
      .port_power_i    (power),
      .cmd_reset_i     (c_rst),
      .cmd_disable_i   (c_dis),
      .cmd_suspend_i   (c_sus),
      .cmd_resume_i    (c_res),
      .drive_en_o      (drive_en),
      .drive_line_o    (drive_line),
      .state_o         (state),
      .connected_o     (connected),
      .port_enabled_o  (port_enabled),
      .port_suspended_o(port_suspended),
      .low_speed_o     (low_speed),
      .j_state_o       (j_state),
      .k_state_o       (k_state),
      .idle_state_o    (idle_state),
      .conn_change_o   (conn_change),
      .reset_done_o    (reset_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_st    = SOff;
      t_enter = cyc;
      se0_run = 0;
      m_cap   = 2'b00;
      m_j     = 2'b10;
      m_low   = 1'b0;
      m_conn  = 1'b0;
      m_rd    = 1'b0;
      p_meta  = 2'b00;
      p_s     = 2'b00;
   endtask

   // One clock edge of the port, described by elapsed time in each state.
   task automatic model_edge();
      logic [1:0] ls;
      int nst, run;
      bit mon, conn, rd;
      ls   = p_s;
      nst  = m_st;
      conn = 1'b0;
      rd   = 1'b0;
      mon  = (m_st == SDisabled || m_st == SEnabled || m_st == SSuspended);
      run  = (mon && ls == 2'b00) ? se0_run + 1 : 0;
      if (!power) begin
         nst  = SOff;
         conn = (m_st >= SDisabled);
      end else if (mon && run >= DiscCyc) begin
         nst  = SDisconn;
         conn = 1'b1;
      end else begin
         case (m_st)
            SOff: nst = SDisconn;
            SDisconn: if (ls == 2'b10 || ls == 2'b01) begin
               nst = SDebounce;
               m_cap = ls;
            end
            SDebounce: begin
               if (ls != m_cap) nst = SDisconn;
               else if (cyc - t_enter >= DebCyc) begin
                  nst   = SDisabled;
                  m_j   = m_cap;
                  m_low = (m_cap == 2'b01);
                  conn  = 1'b1;
               end
            end
            SDisabled: if (c_rst) nst = SResetting;
            SResetting: begin
               if (c_rst) t_enter = cyc;
               else if (c_dis) nst = SDisabled;
               else if (cyc - t_enter >= RstCyc) begin
                  nst = SEnabled;
                  rd  = 1'b1;
               end
            end
            SEnabled: begin
               if (c_rst) nst = SResetting;
               else if (c_dis) nst = SDisabled;
               else if (c_sus) nst = SSuspended;
            end
            SSuspended: begin
               if (c_rst) nst = SResetting;
               else if (c_dis) nst = SDisabled;
               else if (c_res || ls == ~m_j) nst = SResuming;
            end
            default: begin
               if (c_rst) nst = SResetting;
               else if (cyc - t_enter >= ResCyc + 2) nst = SEnabled;
            end
         endcase
      end
      if (nst != m_st) begin
         t_enter = cyc;
         run = 0;
      end
      se0_run = run;
      m_st    = nst;
      m_conn  = conn;
      m_rd    = rd;
      p_s     = p_meta;
      p_meta  = line;
   endtask

   task automatic compare_all();
      logic [1:0] exp_dl;
      exp_dl = (m_st == SResuming && cyc - t_enter < ResCyc) ? ~m_j : 2'b00;
      check("state", state, m_st);
      check("drive", {drive_en, drive_line},
            {(m_st == SResetting || m_st == SResuming), exp_dl});
      check("flags", {connected, port_enabled, port_suspended},
            {m_st >= SDisabled, m_st >= SEnabled, m_st >= SSuspended});
      check("latched", {low_speed, j_state, k_state, idle_state}, {m_low, m_j, ~m_j, m_j});
      check("pulses", {conn_change, reset_done}, {m_conn, m_rd});
   endtask

   task automatic step();
      @(posedge clock);
      cyc++;
      model_edge();
      #1;
      compare_all();
      if (reset_done) rd_seen = 1'b1;
      if (conn_change) cc_seen = 1'b1;
      if (state == 3'(SResuming) && drive_en && drive_line == k_state) k_cnt++;
      if (state == 3'(SResuming) && drive_en && drive_line == 2'b00) eop_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // cmd = {reset, disable, suspend, resume}, held for exactly one edge
   task automatic pulse(input logic [3:0] cmd);
      {c_rst, c_dis, c_sus, c_res} = cmd;
      step();
      {c_rst, c_dis, c_sus, c_res} = 4'b0000;
   endtask

   task automatic hold_len(input int s, input int budget, output int len);
      len = 0;
      while (state == 3'(s) && len < budget) begin
         len++;
         step();
      end
   endtask

   task automatic attach(input logic [1:0] j);
      line = j;
      run(DebCyc + 10);
      check("attach_state", state, SDisabled);
   endtask

   int len;
   int cur_j_sel;
   logic [1:0] cur_j;

   initial begin
      reset = 1'b0;
      line  = 2'b00;
      power = 1'b0;
      {c_rst, c_dis, c_sus, c_res} = 4'b0000;
      model_reset();
      #12;
      compare_all();
      check("rst_j", j_state, 2'b10);
      check("rst_k", k_state, 2'b01);
      reset = 1'b1;
      run(3);
      check("off_nopower", state, SOff);

      // Full-speed attach and debounce timing
      power = 1'b1;
      step();
      check("disconn", state, SDisconn);
      line = 2'b10;
      run(2);
      check("pre_deb", state, SDisconn);
      step();
      check("deb_at3", state, SDebounce);
      run(DebCyc - 1);
      check("deb_hold", state, SDebounce);
      step();
      check("disabled", state, SDisabled);
      check("attach_cc", conn_change, 1'b1);
      check("fs_speed", {low_speed, j_state, k_state}, {1'b0, 2'b10, 2'b01});
      step();
      check("cc_1cyc", conn_change, 1'b0);

      // Disconnect then bounce with an LS-looking line
      line = 2'b00;
      run(5);
      check("disc", state, SDisconn);
      cc_seen = 1'b0;
      line = 2'b01;
      run(50);
      line = 2'b00;
      run(10);
      check("bounce_state", state, SDisconn);
      check("bounce_cc", cc_seen, 1'b0);
      check("bounce_ls", low_speed, 1'b0);

      // Port reset: full length, then an aborted one
      attach(2'b10);
      rd_seen = 1'b0;
      pulse(4'b1000);
      hold_len(SResetting, RstCyc + 50, len);
      check("rst_len", len, RstCyc);
      check("rst_done", reset_done, 1'b1);
      check("rst_enabled", state, SEnabled);
      pulse(4'b1000);
      rd_seen = 1'b0;
      run(199);
      pulse(4'b0100);
      check("abort_state", state, SDisabled);
      run(RstCyc);
      check("abort_nodone", rd_seen, 1'b0);

      // SE0 glitch vs real disconnect in ENABLED
      pulse(4'b1000);
      run(RstCyc);
      check("en2", state, SEnabled);
      line = 2'b00;
      run(2);
      line = 2'b10;
      run(5);
      check("glitch_stay", state, SEnabled);
      cc_seen = 1'b0;
      line = 2'b00;
      run(3);
      line = 2'b10;
      run(2);
      check("disc_en", state, SDisconn);
      check("disc_cc", cc_seen, 1'b1);

      // Low-speed attach, suspend, remote wakeup
      line = 2'b00;
      run(3);
      attach(2'b01);
      check("ls_speed", {low_speed, j_state, k_state, idle_state},
            {1'b1, 2'b01, 2'b10, 2'b01});
      pulse(4'b1000);
      run(RstCyc);
      pulse(4'b0010);
      check("suspended", state, SSuspended);
      k_cnt = 0;
      eop_cnt = 0;
      line = 2'b10;
      run(3);
      check("resuming", state, SResuming);
      hold_len(SResuming, ResCyc + 50, len);
      check("res_len", len, ResCyc + 2);
      check("res_k", k_cnt, ResCyc);
      check("res_eop", eop_cnt, 2);
      check("res_en", state, SEnabled);
      line = 2'b01;
      run(3);

      // Power-off beats cmd_reset
      pulse(4'b0100);
      power = 1'b0;
      pulse(4'b1000);
      check("pwr_off", state, SOff);
      check("pwr_cc", conn_change, 1'b1);
      check("pwr_drv", drive_en, 1'b0);

      // Async reset in the middle of a port reset
      power = 1'b1;
      run(2);
      attach(2'b01);
      pulse(4'b1000);
      run(100);
      check("mid_rst", drive_en, 1'b1);
      #1 reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("arst_drv", {drive_en, drive_line}, 3'b000);
      check("arst_state", state, SOff);
      #1 reset = 1'b1;

      // Random traffic
      cur_j = 2'b10;
      for (int ph = 0; ph < 150; ph++) begin
         int r, dur;
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            line = cur_j;
            dur = $urandom_range(20, 300);
         end else if (r <= 7) begin
            line = 2'b00;
            dur = $urandom_range(1, 5);
         end else if (r == 8) begin
            line = ~cur_j;
            dur = $urandom_range(1, 8);
         end else begin
            cur_j_sel = $urandom_range(0, 3);
            cur_j = (cur_j_sel == 3) ? 2'b11 : ((cur_j_sel[0]) ? 2'b01 : 2'b10);
            line = cur_j;
            dur = $urandom_range(5, 120);
         end
         for (int i = 0; i < dur; i++) begin
            power = ($urandom_range(0, 999) != 0);
            c_rst = ($urandom_range(0, 199) == 0);
            c_dis = ($urandom_range(0, 399) == 0);
            c_sus = ($urandom_range(0, 99) == 0);
            c_res = ($urandom_range(0, 149) == 0);
            step();
         end
         {c_rst, c_dis, c_sus, c_res} = 4'b0000;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
